// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial adder controller.
//
// A single 4-bit ripple adder (adder_4b) is time-shared across all nibbles
// of two W-bit operands (W = 4*NIBBLES). One nibble is processed per clock.
// The final carry is registered as Cout, and the full sum is registered as S.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  request; sampled only in IDLE or DONE
//   A, B   in   W  operands, captured on an accepted start
//   Cin    in   1  carry into nibble 0, captured on an accepted start
//   sub    in   1  subtract select (only when SERIAL_ADD_SUB_EN is defined)
//   busy   out  1  high while an operation is running
//   done   out  1  one-cycle pulse when a result has just been committed
//   S      out  W  last completed result
//   Cout   out  1  carry out of the top nibble of the last result
//
// Optional feature: define SERIAL_ADD_SUB_EN to add the sub port.
// With sub=1 the B slices are inverted and the initial carry is forced to 1,
// so S = A - B and Cout=1 means "no borrow".

// Plain 4-bit ripple-carry adder built from gate-level full adders.
module adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   Cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
  logic            sub_q, sub_d;
`endif

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      sum_nib;
  logic            add_cout;
  logic            accept;

  // Operand slice selection for the shared adder. In subtract mode the
  // B slice is inverted; together with the forced initial carry of 1 this
  // forms the two's complement of B.
  always_comb begin
    a_nib = a_q[4*idx_q +: 4];
`ifdef SERIAL_ADD_SUB_EN
    b_nib = b_q[4*idx_q +: 4] ^ {4{sub_q}};
`else
    b_nib = b_q[4*idx_q +: 4];
`endif
  end

  adder_4b u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (add_cout)
  );

  // Next-state and datapath logic. A start is honoured only in IDLE or
  // DONE, so the captured operands are frozen for the whole RUN phase.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[4*idx_q +: 4] = sum_nib;
        carry_d             = add_cout;
        if (idx_q == LAST_IDX) begin
          // Last nibble: publish the full result on entry to DONE.
          s_d     = res_d;
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_d   = A;
      b_d   = B;
      res_d = '0;
      idx_d = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = sub;
      carry_d = sub ? 1'b1 : Cin;
`else
      carry_d = Cin;
`endif
    end
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl with NIBBLES=4.
// Expected results come from a whole-word arithmetic reference model.
module tb_serial_add_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Cin;
   logic          sub;
   logic          busy;
   logic          done;
   logic [W-1:0]  S;
   logic          Cout;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  expS;
   logic          expCout;

   serial_add_ctrl #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: whole-word arithmetic on W+1 bits
   function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef SERIAL_ADD_SUB_EN
      if (s) r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`endif
      return r;
   endfunction

   // Single comparison point with failure accounting
   task automatic checkOutput(input string tag, input logic [W:0] observed, input logic [W:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive a request at a negedge and compute its expected result
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic s);
      logic [W:0] r;
      A     = a;
      B     = b;
      Cin   = c;
      sub   = s;
      start = 1'b1;
      r       = refModel(a, b, c, s);
      expS    = r[W-1:0];
      expCout = r[W];
   endtask

   // Full operation from a negedge to the negedge of the DONE cycle.
   // midStart pulses start with other operands during RUN.
   task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input bit midStart);
      applyStimulus(a, b, c, s);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         checkOutput({tag, " busy"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
         checkOutput({tag, " noDone"}, {{W{1'b0}}, done}, '0);
         if (midStart && i == 1) begin
            start = 1'b1;
            A     = 16'h0F0F;
            B     = 16'h0F0F;
         end else if (midStart && i == 2) begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput({tag, " done"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
      checkOutput({tag, " busyLow"}, {{W{1'b0}}, busy}, '0);
      checkOutput({tag, " S"}, {1'b0, S}, {1'b0, expS});
      checkOutput({tag, " Cout"}, {{W{1'b0}}, Cout}, {{W{1'b0}}, expCout});
   endtask

   // One idle cycle after DONE: done must drop, result must hold
   task automatic idleCycle(input string tag);
      @(negedge clk);
      checkOutput({tag, " doneDrop"}, {{W{1'b0}}, done}, '0);
      checkOutput({tag, " idleBusy"}, {{W{1'b0}}, busy}, '0);
      checkOutput({tag, " holdS"}, {Cout, S}, {expCout, expS});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      Cin   = 1'b0;
      sub   = 1'b0;

      // Reset state
      #1;
      checkOutput("rst busy", {{W{1'b0}}, busy}, '0);
      checkOutput("rst done", {{W{1'b0}}, done}, '0);
      checkOutput("rst S", {Cout, S}, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // First start accepted on the first edge after reset release
      runOp("add1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      idleCycle("add1234");

      runOp("rippleFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      idleCycle("rippleFFFF");

      // Back-to-back: start held in DONE goes straight to RUN
      runOp("cinFFFF", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      runOp("backToBack", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      idleCycle("backToBack");

      // Start during RUN is ignored
      runOp("ignoreMid", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < N + 2; i++) idleCycle("ignoreMid");

      // Reset in the middle of RUN, between edges
      applyStimulus(16'h7777, 16'h1111, 1'b1, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midRst busy", {{W{1'b0}}, busy}, '0);
      checkOutput("midRst done", {{W{1'b0}}, done}, '0);
      checkOutput("midRst S", {Cout, S}, '0);
      @(negedge clk);
      rst = 1'b0;
      expS    = '0;
      expCout = 1'b0;
      for (int i = 0; i < N + 2; i++) idleCycle("postRst");
      runOp("afterRst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      idleCycle("afterRst");

`ifdef SERIAL_ADD_SUB_EN
      runOp("sub5m3", 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0);
      idleCycle("sub5m3");
      runOp("sub3m5", 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
      idleCycle("sub3m5");
`endif

      // Randomized operations, some back-to-back
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         runOp("rand", ra, rb, rc, rs, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idleCycle("rand");
      end
      idleCycle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
